// File: rtl/mc_maindec.sv
// Multi-cycle main control FSM for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB with memory handshakes, timeout and halt.
module mc_maindec #(
    parameter int TIMEOUT_W       = 8,
    parameter int MEM_TIMEOUT     = 255,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       memwrite,
    output logic       memtoreg,
    output logic [2:0] memsize,
    output logic       branch,
    output logic       jump,
    output logic       jumpsrc,
    output logic [1:0] alusrc,
    output logic       alusrc_a_zero,
    output logic       regwrite,
    output logic       pc_we,
    output logic       hlt,
    output logic [1:0] fault,
    output logic [2:0] state
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_SRC_REG = 2'd0;
    localparam logic [1:0] ALU_SRC_IMM = 2'd1;
    localparam logic [1:0] ALU_SRC_PC  = 2'd2;
    localparam logic [1:0] ALU_SRC_NPC = 2'd3;

    localparam logic [TIMEOUT_W-1:0] TMO     = TIMEOUT_W'(MEM_TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam bit                   TMO_EN  = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic [1:0] alusrc;
        logic       a_zero;
        logic [2:0] memsize;
    } ctl_t;

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [1:0]           fault_q, fault_d;
    ctl_t                 ctl_q, ctl_dec;
    logic                 dec_illegal;
    logic                 dec_system;
    logic                 wait_expired;

    assign wait_expired = TMO_EN && (cnt_q == TMO);

    // Opcode table: per-instruction controls captured at DECODE
    always_comb begin
        ctl_dec     = '0;
        dec_illegal = 1'b0;
        dec_system  = 1'b0;
        unique case (1'b1)
            op == OP_BRANCH: begin
                ctl_dec.is_branch = 1'b1;
                ctl_dec.alusrc    = ALU_SRC_REG;
            end
            op == OP_JAL: begin
                ctl_dec.is_jal = 1'b1;
                ctl_dec.alusrc = ALU_SRC_NPC;
                ctl_dec.a_zero = 1'b1;
            end
            op == OP_JALR: begin
                ctl_dec.is_jalr = 1'b1;
                ctl_dec.alusrc  = ALU_SRC_NPC;
                ctl_dec.a_zero  = 1'b1;
            end
            op == OP_LOAD: begin
                ctl_dec.is_load = 1'b1;
                ctl_dec.alusrc  = ALU_SRC_IMM;
                ctl_dec.memsize = funct3;
            end
            op == OP_STORE: begin
                ctl_dec.is_store = 1'b1;
                ctl_dec.alusrc   = ALU_SRC_IMM;
                ctl_dec.memsize  = funct3;
            end
            op == OP_LUI: begin
                ctl_dec.alusrc = ALU_SRC_IMM;
                ctl_dec.a_zero = 1'b1;
            end
            op == OP_AUIPC: begin
                ctl_dec.alusrc = ALU_SRC_PC;
                ctl_dec.a_zero = 1'b1;
            end
            op == OP_I: ctl_dec.alusrc = ALU_SRC_IMM;
            op == OP_R: ctl_dec.alusrc = ALU_SRC_REG;
            op == OP_SYSTEM: dec_system = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next state, fault capture and per-state strobes
    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        jumpsrc  = 1'b0;
        regwrite = 1'b0;
        pc_we    = 1'b0;
        hlt      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    fault_d = 2'd2;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (dec_system) begin
                    state_d = S_HALT;
                end else if (dec_illegal) begin
                    fault_d = 2'd1;
                    if (HALT_ON_ILLEGAL) begin
                        state_d = S_HALT;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                jump    = ctl_q.is_jal | ctl_q.is_jalr;
                jumpsrc = ctl_q.is_jalr;
                if (ctl_q.is_branch) begin
                    branch  = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end else if (ctl_q.is_load | ctl_q.is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                memwrite = ctl_q.is_store;
                if (dmem_ready) begin
                    if (ctl_q.is_store) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    fault_d = 2'd3;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                pc_we    = 1'b1;
                memtoreg = ctl_q.is_load;
                jump     = ctl_q.is_jal | ctl_q.is_jalr;
                jumpsrc  = ctl_q.is_jalr;
                state_d  = S_FETCH;
            end
            S_HALT: hlt = 1'b1;
            default: state_d = S_HALT;
        endcase
    end

    // Wait counter restarts on every state change and saturates
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) &&
                     cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, wait counter, sticky fault and latched decode controls
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            fault_q <= 2'd0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            if (state_q == S_DECODE) begin
                ctl_q <= ctl_dec;
            end
        end
    end

    assign memsize       = ctl_q.memsize;
    assign alusrc        = ctl_q.alusrc;
    assign alusrc_a_zero = ctl_q.a_zero;
    assign fault         = fault_q;
    assign state         = state_q;

endmodule
